// File: rtl/ps2_scancode_decoder_if.sv
// Bundles the receiver-facing ingress signals and the event/status egress of the scancode decoder.
// The slave modport is the decoder's view; master is the receiver/consumer side.
interface ps2_scancode_decoder_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int ERR_W      = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       ps2_byte;
  logic             ps2_ready;
  logic             ps2_error;
  logic             clear;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic [7:0]       evt_ascii;
  logic             shift_held;
  logic [LVL_W-1:0] fifo_level;
  logic [ERR_W-1:0] err_cnt;
  logic             overflow;

  modport master (
    output ps2_byte, ps2_ready, ps2_error, clear, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
           shift_held, fifo_level, err_cnt, overflow
  );

  modport slave (
    input  ps2_byte, ps2_ready, ps2_error, clear, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
           shift_held, fifo_level, err_cnt, overflow
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Turns PS/2 Set-2 scancode bytes into press/release key events with ASCII, buffered in a FWFT FIFO.
// Also tracks shift state and counts receiver frame errors.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ERR_W      = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  ps2_scancode_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } evt_t;

  logic             ready_s1;
  logic             ready_s2;
  logic             ready_s3;
  logic             strobe;
  state_t           state;
  logic [2:0]       pcnt;
  logic             gen;
  logic             gen_ext;
  logic             gen_brk;
  logic             shift_l;
  logic             shift_r;
  evt_t             entry;
  evt_t             head;
  evt_t             mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             full;
  logic             pop;
  logic             do_push;
  logic             drop;
  logic [ERR_W-1:0] err_cnt_q;
  logic             overflow_q;

  function automatic logic [7:0] key_ascii(input logic [7:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
      8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
      8'h3E: a = "8";  8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      8'h0D: a = 8'h09;
      default: a = 8'h00;
    endcase
    if (shift && (a >= "a") && (a <= "z")) begin
      a = a - 8'h20;
    end
    return a;
  endfunction

  // ps2_ready is a level from another timing domain; only its rising edge marks a new byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_s1 <= 1'b0;
      ready_s2 <= 1'b0;
      ready_s3 <= 1'b0;
    end else begin
      ready_s1 <= bus.ps2_ready;
      ready_s2 <= ready_s1;
      ready_s3 <= ready_s2;
    end
  end

  assign strobe = ready_s2 & ~ready_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt  <= 3'd0;
    end else if (strobe) begin
      if (bus.ps2_error) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            case (bus.ps2_byte)
              8'hE0: state <= EXT;
              8'hF0: state <= BRK;
              8'hE1: begin
                state <= PAUSE;
                pcnt  <= 3'd7;
              end
              default: state <= IDLE;
            endcase
          end
          EXT:         state <= (bus.ps2_byte == 8'hF0) ? EXTBRK : IDLE;
          BRK, EXTBRK: state <= IDLE;
          PAUSE: begin
            pcnt <= pcnt - 3'd1;
            if (pcnt == 3'd1) begin
              state <= IDLE;
            end
          end
          default:     state <= IDLE;
        endcase
      end
    end
  end

  // Event generation for the byte on the current strobe; the pause prefix itself is the only pause event
  always_comb begin
    gen     = 1'b0;
    gen_ext = 1'b0;
    gen_brk = 1'b0;
    if (strobe && !bus.ps2_error) begin
      case (state)
        IDLE: begin
          case (bus.ps2_byte)
            8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: gen = 1'b0;
            default: gen = 1'b1;
          endcase
        end
        EXT: begin
          if ((bus.ps2_byte != 8'hF0) && (bus.ps2_byte != 8'hE0) && (bus.ps2_byte != 8'hE1)) begin
            gen     = 1'b1;
            gen_ext = 1'b1;
          end
        end
        BRK: begin
          gen     = 1'b1;
          gen_brk = 1'b1;
        end
        EXTBRK: begin
          gen     = 1'b1;
          gen_ext = 1'b1;
          gen_brk = 1'b1;
        end
        default: gen = 1'b0;
      endcase
    end
  end

  always_comb begin
    entry.code  = bus.ps2_byte;
    entry.ext   = gen_ext;
    entry.brk   = gen_brk;
    entry.ascii = gen_ext ? 8'h00 : key_ascii(bus.ps2_byte, shift_l | shift_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (gen && !gen_ext) begin
      if (bus.ps2_byte == 8'h12) begin
        shift_l <= ~gen_brk;
      end
      if (bus.ps2_byte == 8'h59) begin
        shift_r <= ~gen_brk;
      end
    end
  end

  assign full    = (count == LW'(FIFO_DEPTH));
  assign pop     = bus.evt_valid & bus.evt_ready;
  assign do_push = gen & (~full | pop);
  assign drop    = gen & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // A pop frees the slot this cycle, so a push into a full FIFO with a pop is never dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (strobe && bus.ps2_error && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.evt_valid  = (count != '0);
  assign bus.evt_code   = bus.evt_valid ? head.code  : 8'h00;
  assign bus.evt_ext    = bus.evt_valid ? head.ext   : 1'b0;
  assign bus.evt_break  = bus.evt_valid ? head.brk   : 1'b0;
  assign bus.evt_ascii  = bus.evt_valid ? head.ascii : 8'h00;
  assign bus.shift_held = shift_l | shift_r;
  assign bus.fifo_level = count;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed vector table, timing corner sequences,
// and randomized key traffic scored against a key-level reference model.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 8;
  localparam int ERR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_scancode_decoder_if #(.FIFO_DEPTH(DEPTH), .ERR_W(ERR_W)) bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } evt_t;

  typedef struct {
    logic [23:0] seq;
    int          nb;
    logic        has_evt;
    evt_t        evt;
    logic        shift;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  evt_t exp_q[$];
  bit   rand_on = 1'b0;
  bit   model_l = 1'b0;
  bit   model_r = 1'b0;
  int   model_err = 0;

  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                    8'h3E, 8'h46};
  byte unsigned misc_codes[8]   = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h05, 8'h14, 8'h11};
  byte unsigned fill_codes[9]   = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

  function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit shift);
    for (int i = 0; i < 26; i++) begin
      if (letter_codes[i] == code) return shift ? 8'(65 + i) : 8'(97 + i);
    end
    for (int i = 0; i < 10; i++) begin
      if (digit_codes[i] == code) return 8'(48 + i);
    end
    case (code)
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      8'h0D:   return 8'h09;
      default: return 8'h00;
    endcase
  endfunction

  function automatic evt_t mk_evt(input logic [7:0] code, input logic ext, input logic brk,
                                  input logic [7:0] ascii);
    evt_t e;
    e.code  = code;
    e.ext   = ext;
    e.brk   = brk;
    e.ascii = ascii;
    return e;
  endfunction

  function automatic evt_t head_evt();
    return mk_evt(bus.evt_code, bus.evt_ext, bus.evt_break, bus.evt_ascii);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic err, input int hi, input int lo);
    @(negedge clk);
    bus.ps2_byte  = b;
    bus.ps2_error = err;
    bus.ps2_ready = 1'b1;
    repeat (hi) @(negedge clk);
    bus.ps2_ready = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 3, 2);
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
  endtask

  task automatic add_vec(input logic [23:0] seq, input int nb, input logic has,
                         input logic [7:0] code, input logic ext, input logic brk,
                         input logic [7:0] ascii, input logic shift);
    vec_t v;
    v.seq     = seq;
    v.nb      = nb;
    v.has_evt = has;
    v.evt     = mk_evt(code, ext, brk, ascii);
    v.shift   = shift;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    for (int i = 0; i < v.nb; i++) begin
      send(v.seq[23 - 8*i -: 8]);
    end
    check_output({tag, "_level"}, 32'(bus.fifo_level), 32'(v.has_evt));
    if (v.has_evt) begin
      check_output({tag, "_evt"}, head_evt(), v.evt);
    end
    check_output({tag, "_shift"}, bus.shift_held, v.shift);
    if (v.has_evt) pop_one();
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 3))
      0:       return letter_codes[$urandom_range(0, 25)];
      1:       return digit_codes[$urandom_range(0, 9)];
      2:       return misc_codes[$urandom_range(0, 7)];
      default: return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
    endcase
  endfunction

  task automatic random_send(input logic [7:0] b, input logic err);
    send_frame(b, err, $urandom_range(3, 5), $urandom_range(2, 4));
  endtask

  // The model works per key action, not per byte: each action knows its bytes and its event up front
  task automatic random_action();
    logic [7:0] k;
    bit         sh;
    int         a;
    k  = pick_key();
    sh = model_l | model_r;
    a  = $urandom_range(0, 9);
    case (a)
      0, 1, 2: begin
        exp_q.push_back(mk_evt(k, 1'b0, 1'b0, model_ascii(k, sh)));
        if (k == 8'h12) model_l = 1'b1;
        if (k == 8'h59) model_r = 1'b1;
        random_send(k, 1'b0);
      end
      3, 4: begin
        exp_q.push_back(mk_evt(k, 1'b0, 1'b1, model_ascii(k, sh)));
        if (k == 8'h12) model_l = 1'b0;
        if (k == 8'h59) model_r = 1'b0;
        random_send(8'hF0, 1'b0);
        random_send(k, 1'b0);
      end
      5: begin
        exp_q.push_back(mk_evt(k, 1'b1, 1'b0, 8'h00));
        random_send(8'hE0, 1'b0);
        random_send(k, 1'b0);
      end
      6: begin
        exp_q.push_back(mk_evt(k, 1'b1, 1'b1, 8'h00));
        random_send(8'hE0, 1'b0);
        random_send(8'hF0, 1'b0);
        random_send(k, 1'b0);
      end
      7: begin
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        exp_q.push_back(mk_evt(8'hE1, 1'b0, 1'b0, 8'h00));
        for (int i = 0; i < 8; i++) random_send(pause_seq[i], 1'b0);
      end
      8: begin
        model_err++;
        if ($urandom_range(0, 1) != 0) begin
          random_send(($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0, 1'b0);
        end
        random_send(8'($urandom), 1'b1);
      end
      default: begin
        logic [7:0] ign [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        random_send(ign[$urandom_range(0, 5)], 1'b0);
      end
    endcase
  endtask

  initial begin
    evt_t e;
    int   n;
    bus.ps2_byte  = 8'h00;
    bus.ps2_ready = 1'b0;
    bus.ps2_error = 1'b0;
    bus.clear     = 1'b0;
    bus.evt_ready = 1'b0;

    #2;
    check_output("rst_valid", bus.evt_valid, 1'b0);
    check_output("rst_level", 32'(bus.fifo_level), 32'd0);
    check_output("rst_err", 32'(bus.err_cnt), 32'd0);
    check_output("rst_ovf", bus.overflow, 1'b0);
    check_output("rst_shift", bus.shift_held, 1'b0);
    check_output("rst_evt", head_evt(), 18'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    add_vec(24'h1C0000, 1, 1, 8'h1C, 0, 0, 8'h61, 0);
    add_vec(24'hF01C00, 2, 1, 8'h1C, 0, 1, 8'h61, 0);
    add_vec(24'h120000, 1, 1, 8'h12, 0, 0, 8'h00, 1);
    add_vec(24'h1C0000, 1, 1, 8'h1C, 0, 0, 8'h41, 1);
    add_vec(24'h160000, 1, 1, 8'h16, 0, 0, 8'h31, 1);
    add_vec(24'hF01C00, 2, 1, 8'h1C, 0, 1, 8'h41, 1);
    add_vec(24'hE01200, 2, 1, 8'h12, 1, 0, 8'h00, 1);
    add_vec(24'hE0F012, 3, 1, 8'h12, 1, 1, 8'h00, 1);
    add_vec(24'hF01200, 2, 1, 8'h12, 0, 1, 8'h00, 0);
    add_vec(24'h590000, 1, 1, 8'h59, 0, 0, 8'h00, 1);
    add_vec(24'h4D0000, 1, 1, 8'h4D, 0, 0, 8'h50, 1);
    add_vec(24'hF05900, 2, 1, 8'h59, 0, 1, 8'h00, 0);
    add_vec(24'hE07500, 2, 1, 8'h75, 1, 0, 8'h00, 0);
    add_vec(24'hE0F075, 3, 1, 8'h75, 1, 1, 8'h00, 0);
    add_vec(24'hE01C00, 2, 1, 8'h1C, 1, 0, 8'h00, 0);
    add_vec(24'h290000, 1, 1, 8'h29, 0, 0, 8'h20, 0);
    add_vec(24'h5A0000, 1, 1, 8'h5A, 0, 0, 8'h0D, 0);
    add_vec(24'h660000, 1, 1, 8'h66, 0, 0, 8'h08, 0);
    add_vec(24'h0D0000, 1, 1, 8'h0D, 0, 0, 8'h09, 0);
    add_vec(24'h450000, 1, 1, 8'h45, 0, 0, 8'h30, 0);
    add_vec(24'h1A0000, 1, 1, 8'h1A, 0, 0, 8'h7A, 0);
    add_vec(24'h760000, 1, 1, 8'h76, 0, 0, 8'h00, 0);
    add_vec(24'hAAFAEE, 3, 0, 8'h00, 0, 0, 8'h00, 0);
    add_vec(24'hFE00FF, 3, 0, 8'h00, 0, 0, 8'h00, 0);
    add_vec(24'hE0E000, 2, 0, 8'h00, 0, 0, 8'h00, 0);
    add_vec(24'h1C0000, 1, 1, 8'h1C, 0, 0, 8'h61, 0);
    add_vec(24'hE0E100, 2, 0, 8'h00, 0, 0, 8'h00, 0);
    add_vec(24'h5A0000, 1, 1, 8'h5A, 0, 0, 8'h0D, 0);
    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    check_output("two_level", 32'(bus.fifo_level), 32'd2);
    check_output("two_first", head_evt(), mk_evt(8'h1C, 0, 0, 8'h61));
    pop_one();
    check_output("two_second", head_evt(), mk_evt(8'h1C, 0, 1, 8'h61));
    pop_one();

    @(negedge clk);
    bus.ps2_byte  = 8'h32;
    bus.ps2_error = 1'b0;
    bus.ps2_ready = 1'b1;
    @(negedge clk);
    check_output("lat_e0", bus.evt_valid, 1'b0);
    @(negedge clk);
    check_output("lat_e1", bus.evt_valid, 1'b0);
    @(negedge clk);
    check_output("lat_e2", bus.evt_valid, 1'b1);
    repeat (100) @(negedge clk);
    bus.ps2_ready = 1'b0;
    repeat (4) @(negedge clk);
    check_output("hold_level", 32'(bus.fifo_level), 32'd1);
    pop_one();

    foreach (vecs[i]) if (i < 0) send(8'h00);
    begin
      logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send(pause_seq[i]);
    end
    check_output("pause_level", 32'(bus.fifo_level), 32'd1);
    check_output("pause_evt", head_evt(), mk_evt(8'hE1, 0, 0, 8'h00));
    pop_one();
    send(8'h1C);
    check_output("after_pause", head_evt(), mk_evt(8'h1C, 0, 0, 8'h61));
    pop_one();

    send_frame(8'h1C, 1'b1, 3, 2);
    check_output("err_level", 32'(bus.fifo_level), 32'd0);
    check_output("err_cnt1", 32'(bus.err_cnt), 32'd1);
    send(8'hE0);
    send_frame(8'h75, 1'b1, 3, 2);
    send(8'h1C);
    check_output("err_drop_ext", head_evt(), mk_evt(8'h1C, 0, 0, 8'h61));
    check_output("err_cnt2", 32'(bus.err_cnt), 32'd2);
    pop_one();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check_output("clear_err", 32'(bus.err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) send_frame(8'h1C, 1'b1, 3, 2);
    check_output("err_sat", 32'(bus.err_cnt), 32'hFF);
    bus.clear = 1'b1;
    send_frame(8'h1C, 1'b1, 3, 2);
    bus.clear = 1'b0;
    check_output("clear_wins", 32'(bus.err_cnt), 32'd0);

    for (int i = 0; i < 9; i++) send(fill_codes[i]);
    check_output("ovf_level", 32'(bus.fifo_level), 32'd8);
    check_output("ovf_flag", bus.overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("ovf_pop%0d", i), 32'(bus.evt_code), 32'(fill_codes[i]));
      pop_one();
    end
    check_output("ovf_empty", 32'(bus.fifo_level), 32'd0);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check_output("ovf_clear", bus.overflow, 1'b0);

    for (int i = 0; i < 8; i++) send(fill_codes[i]);
    @(negedge clk);
    bus.ps2_byte  = fill_codes[8];
    bus.ps2_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.evt_ready = 1'b1;
    @(negedge clk);
    bus.evt_ready = 1'b0;
    bus.ps2_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pp_level", 32'(bus.fifo_level), 32'd8);
    check_output("pp_ovf", bus.overflow, 1'b0);
    for (int i = 1; i < 9; i++) begin
      check_output($sformatf("pp_pop%0d", i), 32'(bus.evt_code), 32'(fill_codes[i]));
      pop_one();
    end

    send(8'h12);
    for (int i = 0; i < 8; i++) send(fill_codes[i]);
    send(8'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_level", 32'(bus.fifo_level), 32'd0);
    check_output("arst_ovf", bus.overflow, 1'b0);
    check_output("arst_shift", bus.shift_held, 1'b0);
    check_output("arst_valid", bus.evt_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h1C);
    check_output("arst_idle", head_evt(), mk_evt(8'h1C, 0, 0, 8'h61));
    pop_one();

    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk);
          bus.evt_ready = ($urandom_range(0, 1) != 0);
          if (bus.evt_valid && bus.evt_ready) begin
            if (exp_q.size() == 0) begin
              check_output("rand_unexpected", 1'b1, 1'b0);
            end else begin
              e = exp_q.pop_front();
              check_output("rand_evt", head_evt(), e);
            end
          end
        end
        bus.evt_ready = 1'b0;
      end
    join_none
    for (int i = 0; i < 200; i++) random_action();
    n = 0;
    while ((exp_q.size() != 0 || bus.evt_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    rand_on = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rand_drained", 32'(exp_q.size()), 32'd0);
    check_output("rand_level", 32'(bus.fifo_level), 32'd0);
    check_output("rand_err", 32'(bus.err_cnt), 32'(model_err));
    check_output("rand_ovf", bus.overflow, 1'b0);
    check_output("rand_shift", bus.shift_held, model_l | model_r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
